cv32e41p_wb_port_arbiter: RTL and testbench
===========================================

# cv32e41p_wb_port_arbiter

Arbitrates the EX/WB register-file write port between load data from the LSU and two-cycle APU/FPU results. The LSU always wins; an APU result that loses is parked in a small in-order holding buffer and retired on the next free cycle. The block sits between the EX/WB pipeline register and the register file. It exports a stall to EX and a read-hazard flag to ID so parked results are never lost or read stale.

## Interface
Parameters:
- DEPTH, 2, number of holding-buffer entries (legal range 1..4)

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- lsu_we_i  input  1  LSU write request this cycle
- lsu_waddr_i  input  6  LSU destination register
- lsu_wdata_i  input  32  LSU write data
- apu_valid_i  input  1  APU two-cycle result valid (single-cycle pulse, cannot be back-pressured)
- apu_waddr_i  input  6  APU destination register
- apu_result_i  input  32  APU result
- read_regs_i  input  3x6  registers read by the instruction in ID
- read_regs_valid_i  input  3  valid bit per read_regs_i entry
- regfile_we_o  output  1  write-port enable
- regfile_waddr_o  output  6  write-port address
- regfile_wdata_o  output  32  write-port data
- apu_stall_o  output  1  buffer full; EX must not issue a new APU op
- read_hazard_o  output  1  an ID read operand matches a valid buffered entry
- contention_o  output  1  LSU and an APU source competed this cycle (perf event)
- overflow_o  output  1  APU result dropped because the buffer was full (error pulse)
- buf_count_o  output  $clog2(DEPTH+1)  valid buffered entries

## Operation
- The holding buffer is a circular FIFO of {valid, waddr, wdata} with head and tail pointers (wrap modulo DEPTH) and a count.
- Port priority in each cycle, highest first:
  - lsu_we_i: the port carries LSU data.
  - Buffer non-empty: the port carries the head entry, which is popped.
  - apu_valid_i: the port carries the APU result directly (bypass, no buffering).
  - Otherwise regfile_we_o=0, and waddr/wdata are 0.
- Push rule: apu_valid_i is pushed when the LSU owns the port, or when the buffer is non-empty (preserves order). A push and a pop in the same cycle are allowed; the count is unchanged.
- Supersede rule: the LSU write is always architecturally younger than any parked APU result.
  - When lsu_we_i=1, every valid buffered entry with waddr==lsu_waddr_i has its valid bit cleared.
  - An incoming APU result with the same address is discarded, not pushed.
  - Invalidated entries still occupy a slot. A popped invalid entry drives regfile_we_o=0 for that cycle.
- Overflow: apu_valid_i arrives, the buffer is full, and no pop happens this cycle.
  - The result is dropped and overflow_o pulses.
  - This is a protocol violation, prevented by honouring apu_stall_o.
- contention_o=1 when apu_valid_i=1 and it does not get the port this cycle.
- apu_stall_o = (count == DEPTH).
- read_hazard_o = OR over i, j of (read_regs_valid_i[i] & valid[j] & read_regs_i[i]==waddr[j]), over occupied slots j.

## Timing
- All outputs are combinational from inputs and buffer state, so bypass latency is 0 cycles. The buffer, pointers and count update on the rising clk edge.
- A parked result retires no earlier than the first cycle without lsu_we_i after it was pushed; worst case is bounded by LSU back-to-back length.
- Reset (rst_n low, asynchronous): head=tail=count=0, all valid=0.
  - With inputs idle, every output is 0, including apu_stall_o, read_hazard_o and buf_count_o.
- Reset mid-operation discards all parked entries with no write.
- Simultaneous events:
  - LSU write, APU arrival and non-empty buffer together: LSU writes, APU is pushed, no pop, count+1.
  - Buffer pop and APU arrival: head is written, APU is pushed, count unchanged.

## Structure
- Add DEPTH bounds and a wb_buf_entry_t typedef ({valid, waddr[5:0], wdata[31:0]}) to cv32e41p_pkg.
- Single module. The FIFO storage is simple enough to stay inline, so no sub-module is needed.

## Test plan
- Reset, then apu_valid_i with waddr=5, result=0xDEADBEEF and no LSU → same cycle: we=1, waddr=5, wdata=0xDEADBEEF; count stays 0.
- LSU write (r3, 0x11) together with APU (r7, 0x22) → cycle 0 writes r3; count=1, contention_o=1. Next idle cycle writes r7=0x22; count=0.
- DEPTH=2: LSU busy 3 cycles with APU arriving on cycles 0 and 1 → count=2, apu_stall_o=1. An APU on cycle 2 gives overflow_o=1 with count still 2. Then r-writes drain in arrival order.
- Park APU (r9, 0xAA), then LSU writes r9=0xBB → no later write to r9. The slot drains with we=0, and final r9=0xBB.
- Buffered entry r12 with read_regs_i[1]=12, valid → read_hazard_o=1. It falls to 0 the cycle after the entry is popped.
- Assert rst_n low while count=2 → count=0 immediately and no writes are emitted after release.

Source files
------------

// File: rtl/cv32e41p_wb_port_arbiter_pkg.sv
// Shared types and bounds for the EX/WB write-port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cv32e41p_wb_port_arbiter_pkg;

  // Holding-buffer depth limits; larger buffers make the hazard compare too wide.
  localparam int unsigned WB_BUF_DEPTH_MIN = 1;
  localparam int unsigned WB_BUF_DEPTH_MAX = 4;

  // One parked APU result; valid drops when a younger LSU write supersedes it.
  typedef struct packed {
    logic        valid;
    logic [5:0]  waddr;
    logic [31:0] wdata;
  } wb_buf_entry_t;

endpackage

// File: rtl/cv32e41p_wb_port_arbiter_if.sv
// Bundle of LSU/APU write sources, ID read operands and the register-file write port.
// Latency: n/a (wires only).
// Backpressure: apu_stall_o travels back to EX; the APU source itself cannot be stalled.
interface cv32e41p_wb_port_arbiter_if #(
  parameter int unsigned DEPTH = 2
);
  logic                         lsu_we_i;
  logic [5:0]                   lsu_waddr_i;
  logic [31:0]                  lsu_wdata_i;
  logic                         apu_valid_i;
  logic [5:0]                   apu_waddr_i;
  logic [31:0]                  apu_result_i;
  logic [2:0][5:0]              read_regs_i;
  logic [2:0]                   read_regs_valid_i;
  logic                         regfile_we_o;
  logic [5:0]                   regfile_waddr_o;
  logic [31:0]                  regfile_wdata_o;
  logic                         apu_stall_o;
  logic                         read_hazard_o;
  logic                         contention_o;
  logic                         overflow_o;
  logic [$clog2(DEPTH+1)-1:0]   buf_count_o;

  // Arbiter side.
  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_result_i,
    input  read_regs_i, read_regs_valid_i,
    output regfile_we_o, regfile_waddr_o, regfile_wdata_o,
    output apu_stall_o, read_hazard_o, contention_o, overflow_o, buf_count_o
  );

  // Pipeline side driving the arbiter.
  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_result_i,
    output read_regs_i, read_regs_valid_i,
    input  regfile_we_o, regfile_waddr_o, regfile_wdata_o,
    input  apu_stall_o, read_hazard_o, contention_o, overflow_o, buf_count_o
  );

endinterface

// File: rtl/cv32e41p_wb_port_arbiter.sv
// Shares the register-file write port: LSU first, then parked APU results, then APU bypass.
// Latency: 0 cycles for LSU and bypassed APU writes; parked results retire on the next LSU-free cycle.
// Backpressure: apu_stall_o when the buffer is full; an APU result arriving anyway is dropped with overflow_o.
module cv32e41p_wb_port_arbiter
  import cv32e41p_wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  cv32e41p_wb_port_arbiter_if.slave wb
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < WB_BUF_DEPTH_MIN || DEPTH > WB_BUF_DEPTH_MAX) begin : g_depth_check
    $error("cv32e41p_wb_port_arbiter: DEPTH out of range");
  end

  wb_buf_entry_t buf_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic          buf_empty, buf_full;
  logic          pop, push;
  logic          lsu_supersedes_apu;
  logic          apu_needs_buf;
  wb_buf_entry_t head_ent;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decide pop/push: the buffer drains only when the LSU leaves the port free,
  // and an APU result is parked whenever it cannot take the port directly.
  always_comb begin
    buf_empty          = (count_q == '0);
    buf_full           = (count_q == CW'(DEPTH));
    head_ent           = buf_q[head_q];
    pop                = !wb.lsu_we_i && !buf_empty;
    lsu_supersedes_apu = wb.lsu_we_i && (wb.apu_waddr_i == wb.lsu_waddr_i);
    apu_needs_buf      = wb.apu_valid_i && (wb.lsu_we_i || !buf_empty);
    push               = apu_needs_buf && !lsu_supersedes_apu && (!buf_full || pop);
  end

  // Write-port mux and status flags; an invalidated head still consumes its pop cycle.
  always_comb begin
    wb.regfile_we_o    = 1'b0;
    wb.regfile_waddr_o = '0;
    wb.regfile_wdata_o = '0;
    if (wb.lsu_we_i) begin
      wb.regfile_we_o    = 1'b1;
      wb.regfile_waddr_o = wb.lsu_waddr_i;
      wb.regfile_wdata_o = wb.lsu_wdata_i;
    end else if (!buf_empty) begin
      if (head_ent.valid) begin
        wb.regfile_we_o    = 1'b1;
        wb.regfile_waddr_o = head_ent.waddr;
        wb.regfile_wdata_o = head_ent.wdata;
      end
    end else if (wb.apu_valid_i) begin
      wb.regfile_we_o    = 1'b1;
      wb.regfile_waddr_o = wb.apu_waddr_i;
      wb.regfile_wdata_o = wb.apu_result_i;
    end
    wb.contention_o = apu_needs_buf;
    wb.overflow_o   = apu_needs_buf && !lsu_supersedes_apu && buf_full && !pop;
    wb.apu_stall_o  = buf_full;
    wb.buf_count_o  = count_q;
  end

  // Flag ID operands that would read a register whose newest value is still parked.
  always_comb begin
    wb.read_hazard_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (wb.read_regs_valid_i[i] && buf_q[j].valid &&
            (wb.read_regs_i[i] == buf_q[j].waddr)) begin
          wb.read_hazard_o = 1'b1;
        end
      end
    end
  end

  // Buffer state: supersede on LSU write, clear valid on pop so only occupied
  // slots ever carry valid=1, then park the incoming APU result at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        buf_q[j] <= '0;
      end
    end else begin
      if (wb.lsu_we_i) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (buf_q[j].valid && (buf_q[j].waddr == wb.lsu_waddr_i)) begin
            buf_q[j].valid <= 1'b0;
          end
        end
      end
      if (pop) begin
        buf_q[head_q].valid <= 1'b0;
        head_q              <= ptr_inc(head_q);
      end
      if (push) begin
        buf_q[tail_q] <= '{valid: 1'b1, waddr: wb.apu_waddr_i, wdata: wb.apu_result_i};
        tail_q        <= ptr_inc(tail_q);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_cv32e41p_wb_port_arbiter.sv
// Directed and random checks of the write-port arbiter against a queue-based model.
// Latency: outputs checked mid-cycle, model advanced on each rising edge.
// Backpressure: random APU traffic mostly honours apu_stall_o, occasionally violates it.
module tb_cv32e41p_wb_port_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    bit       v;
    bit [5:0] a;
    bit [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  ent_t q[$];
  logic [31:0] rf [64];

  always #5 clk = ~clk;

  cv32e41p_wb_port_arbiter_if #(.DEPTH(DEPTH)) wb ();

  cv32e41p_wb_port_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit lw, input bit [5:0] la, input bit [31:0] ld,
                       input bit av, input bit [5:0] aa, input bit [31:0] ad);
    wb.lsu_we_i     = lw;
    wb.lsu_waddr_i  = la;
    wb.lsu_wdata_i  = ld;
    wb.apu_valid_i  = av;
    wb.apu_waddr_i  = aa;
    wb.apu_result_i = ad;
  endtask

  task automatic reads(input bit [2:0] v, input bit [5:0] r0, input bit [5:0] r1, input bit [5:0] r2);
    wb.read_regs_valid_i = v;
    wb.read_regs_i[0]    = r0;
    wb.read_regs_i[1]    = r1;
    wb.read_regs_i[2]    = r2;
  endtask

  // Expected outputs from the arbitration rules applied to the model queue.
  task automatic model_check(input string tag);
    bit lw, av, ew, ec, eo, eh, same;
    bit [5:0] ea;
    bit [31:0] ed;
    int n;
    lw = wb.lsu_we_i;
    av = wb.apu_valid_i;
    n  = q.size();
    ew = 0; ea = 0; ed = 0;
    if (lw) begin
      ew = 1; ea = wb.lsu_waddr_i; ed = wb.lsu_wdata_i;
    end else if (n > 0) begin
      ew = q[0].v;
      if (q[0].v) begin ea = q[0].a; ed = q[0].d; end
    end else if (av) begin
      ew = 1; ea = wb.apu_waddr_i; ed = wb.apu_result_i;
    end
    same = lw && (wb.apu_waddr_i == wb.lsu_waddr_i);
    ec = av && (lw || n > 0);
    eo = av && lw && !same && (n == DEPTH);
    eh = 0;
    for (int i = 0; i < 3; i++)
      foreach (q[j])
        if (wb.read_regs_valid_i[i] && q[j].v && q[j].a == wb.read_regs_i[i]) eh = 1;
    check({tag, ".we"},    wb.regfile_we_o,    ew);
    check({tag, ".waddr"}, wb.regfile_waddr_o, ea);
    check({tag, ".wdata"}, wb.regfile_wdata_o, ed);
    check({tag, ".cont"},  wb.contention_o,    ec);
    check({tag, ".ovf"},   wb.overflow_o,      eo);
    check({tag, ".haz"},   wb.read_hazard_o,   eh);
    check({tag, ".stall"}, wb.apu_stall_o,     n == DEPTH);
    check({tag, ".count"}, wb.buf_count_o,     n);
  endtask

  task automatic settle(input string tag);
    #2;
    model_check(tag);
  endtask

  // Advance the model by one clock using the current inputs, record DUT writes, then clock.
  task automatic tick();
    bit lw, av, pop, push, same;
    lw   = wb.lsu_we_i;
    av   = wb.apu_valid_i;
    same = lw && (wb.apu_waddr_i == wb.lsu_waddr_i);
    pop  = !lw && q.size() > 0;
    push = av && (lw || q.size() > 0) && !same && (q.size() < DEPTH || pop);
    if (wb.regfile_we_o) rf[wb.regfile_waddr_o] = wb.regfile_wdata_o;
    if (lw) foreach (q[j]) if (q[j].v && q[j].a == wb.lsu_waddr_i) q[j].v = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{1'b1, wb.apu_waddr_i, wb.apu_result_i});
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (rf[k]) rf[k] = '0;
    drive(0, 0, 0, 0, 0, 0);
    reads(0, 0, 0, 0);

    // Reset state with idle inputs: everything zero.
    #2;
    check("rst.we",    wb.regfile_we_o,    0);
    check("rst.waddr", wb.regfile_waddr_o, 0);
    check("rst.wdata", wb.regfile_wdata_o, 0);
    check("rst.stall", wb.apu_stall_o,     0);
    check("rst.haz",   wb.read_hazard_o,   0);
    check("rst.cont",  wb.contention_o,    0);
    check("rst.ovf",   wb.overflow_o,      0);
    check("rst.count", wb.buf_count_o,     0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // APU bypass with an empty buffer.
    drive(0, 0, 0, 1, 6'd5, 32'hDEADBEEF);
    settle("byp");
    check("byp.we_c",    wb.regfile_we_o,    1);
    check("byp.waddr_c", wb.regfile_waddr_o, 5);
    check("byp.wdata_c", wb.regfile_wdata_o, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle("byp_after");
    check("byp.count_c", wb.buf_count_o, 0);

    // LSU and APU in the same cycle: APU parks, retires next idle cycle.
    drive(1, 6'd3, 32'h11, 1, 6'd7, 32'h22);
    settle("cont");
    check("cont.waddr_c", wb.regfile_waddr_o, 3);
    check("cont.cont_c",  wb.contention_o,    1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle("cont_drain");
    check("cont.count1_c", wb.buf_count_o,     1);
    check("cont.drain_c",  wb.regfile_waddr_o, 7);
    check("cont.ddata_c",  wb.regfile_wdata_o, 32'h22);
    tick();
    settle("cont_empty");
    check("cont.count0_c", wb.buf_count_o, 0);

    // Fill to DEPTH, overflow on the third arrival, drain in order.
    drive(1, 6'd1, 32'h1, 1, 6'd10, 32'hA0); settle("fill0"); tick();
    drive(1, 6'd2, 32'h2, 1, 6'd11, 32'hA1); settle("fill1"); tick();
    drive(1, 6'd4, 32'h4, 1, 6'd12, 32'hA2); settle("fill2");
    check("full.stall_c", wb.apu_stall_o, 1);
    check("full.count_c", wb.buf_count_o, 2);
    check("full.ovf_c",   wb.overflow_o,  1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    settle("drain0");
    check("ovf.count_c", wb.buf_count_o,     2);
    check("drain0.a_c",  wb.regfile_waddr_o, 10);
    tick();
    settle("drain1");
    check("drain1.a_c",  wb.regfile_waddr_o, 11);
    check("drain1.d_c",  wb.regfile_wdata_o, 32'hA1);
    tick();
    settle("drained");
    check("drained.we_c", wb.regfile_we_o, 0);

    // Supersede: parked r9 replaced by a younger LSU write.
    drive(1, 6'd1, 32'h1, 1, 6'd9, 32'hAA); settle("sup0"); tick();
    drive(1, 6'd9, 32'hBB, 0, 0, 0);        settle("sup1"); tick();
    drive(0, 0, 0, 0, 0, 0);
    settle("sup2");
    check("sup.count_c", wb.buf_count_o,  1);
    check("sup.we0_c",   wb.regfile_we_o, 0);
    tick();
    settle("sup3");
    check("sup.empty_c", wb.buf_count_o, 0);
    check("sup.r9_c",    rf[9],          32'hBB);

    // Read hazard on a parked r12, cleared after its pop.
    drive(1, 6'd1, 32'h1, 1, 6'd12, 32'h12); settle("haz0"); tick();
    drive(0, 0, 0, 0, 0, 0);
    reads(3'b010, 6'd0, 6'd12, 6'd0);
    settle("haz1");
    check("haz.set_c", wb.read_hazard_o, 1);
    tick();
    settle("haz2");
    check("haz.clr_c", wb.read_hazard_o, 0);
    reads(0, 0, 0, 0);

    // Asynchronous reset with two parked entries.
    drive(1, 6'd2, 32'h2, 1, 6'd20, 32'hC0); settle("rr0"); tick();
    drive(1, 6'd3, 32'h3, 1, 6'd21, 32'hC1); settle("rr1"); tick();
    drive(0, 0, 0, 0, 0, 0);
    settle("rr2");
    check("rr.count2_c", wb.buf_count_o, 2);
    rst_n = 1'b0;
    #1;
    check("rr.count0_c", wb.buf_count_o, 0);
    check("rr.stall_c",  wb.apu_stall_o, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle("rr_idle");
      check("rr.nowrite_c", wb.regfile_we_o, 0);
      tick();
    end

    // Random traffic, mostly honouring apu_stall_o.
    for (int n = 0; n < 400; n++) begin
      bit lw, av;
      lw = ($urandom_range(0, 99) < 50);
      if (q.size() == DEPTH) av = ($urandom_range(0, 99) < 5);
      else                   av = ($urandom_range(0, 99) < 45);
      drive(lw, 6'($urandom_range(0, 7)), $urandom,
            av, 6'($urandom_range(0, 7)), $urandom);
      reads(3'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      settle("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
